// File: rtl/keypad_encoder_if.sv
// Bus between the raw push-button lines and the debounced key outputs.
// The slave side is the encoder; the master side drives buttons and observes keys.
interface keypad_encoder_if #(
    parameter int NUM_KEYS = 20
);
    logic [NUM_KEYS-1:0] pb;
    logic [4:0]          keyout;
    logic                strobe;
    logic                pressed;

    modport master (output pb, input keyout, input strobe, input pressed);
    modport slave  (input pb, output keyout, output strobe, output pressed);
endinterface

// File: rtl/keypad_encoder.sv
// Keypad front end: synchronises bouncy buttons, picks the lowest pressed index
// and debounces press/release into a one-cycle strobe plus a held flag.
//
// state    | meaning
// IDLE     | no key seen; waiting for any button
// DEBOUNCE | candidate key must stay the sole lowest index for DEBOUNCE_CYCLES
// HELD     | press accepted; index changes ignored until all keys drop
// RELEASE  | all keys low; must stay low for DEBOUNCE_CYCLES before re-arming
module keypad_encoder #(
    parameter  int NUM_KEYS        = 20,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    keypad_encoder_if.slave  kp
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] s1_q, s2_q;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          cand_q, cand_d;
    logic [4:0]          keyout_q, keyout_d;
    logic                strobe_q, strobe_d;
    logic                pressed_q, pressed_d;
    logic                any;
    logic [4:0]          idx;

    assign any = |s2_q;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        idx = 5'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (s2_q[i]) idx = 5'(i);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= 5'd0;
            keyout_q  <= 5'h1F;
            strobe_q  <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            s1_q      <= kp.pb;
            s2_q      <= s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            keyout_q  <= keyout_d;
            strobe_q  <= strobe_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        keyout_d  = keyout_q;
        strobe_d  = 1'b0;
        pressed_d = pressed_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    cand_d  = idx;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!any || idx != cand_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    keyout_d  = cand_q;
                    strobe_d  = 1'b1;
                    pressed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!any) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (any) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    pressed_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign kp.keyout  = keyout_q;
    assign kp.strobe  = strobe_q;
    assign kp.pressed = pressed_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder: reset, clean press, bounce, priority,
// release glitch and key change during debounce, with hand-computed timing.
module tb_keypad_encoder;
    localparam int NK = 20;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   strobes = 0;
    int   consec = 0;
    logic prev_strobe = 1'b0;
    int   base;

    keypad_encoder_if #(.NUM_KEYS(NK)) bus ();

    keypad_encoder #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .kp   (bus.slave)
    );

    always #5 clk = ~clk;

    // Strobe counter and back-to-back detector, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.strobe) strobes++;
        if (bus.strobe && prev_strobe) consec++;
        prev_strobe = bus.strobe;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input int k);
        bus.pb = '0;
        bus.pb[k] = 1'b1;
    endtask

    initial begin
        bus.pb = '0;
        nrst   = 1'b0;
        tick(3);
        check("rst_keyout", 32'(bus.keyout), 32'h1F);
        check("rst_strobe", 32'(bus.strobe), 32'd0);
        check("rst_pressed", 32'(bus.pressed), 32'd0);
        nrst = 1'b1;
        tick(2);

        // Bounce: high 2 / low 1, never stable long enough
        base = strobes;
        for (int r = 0; r < 4; r++) begin
            key(3); tick(2);
            bus.pb = '0; tick(1);
        end
        tick(10);
        check("bounce_strobes", 32'(strobes - base), 32'd0);
        check("bounce_keyout", 32'(bus.keyout), 32'h1F);
        check("bounce_pressed", 32'(bus.pressed), 32'd0);

        // Clean press of key 5
        base = strobes;
        key(5);
        tick(6);
        check("press_strobe_e6", 32'(bus.strobe), 32'd0);
        check("press_pressed_e6", 32'(bus.pressed), 32'd0);
        tick(1);
        check("press_strobe_e7", 32'(bus.strobe), 32'd1);
        check("press_pressed_e7", 32'(bus.pressed), 32'd1);
        check("press_keyout_e7", 32'(bus.keyout), 32'd5);
        tick(1);
        check("press_strobe_e8", 32'(bus.strobe), 32'd0);
        check("press_pressed_e8", 32'(bus.pressed), 32'd1);
        tick(12);
        bus.pb = '0;
        tick(6);
        check("release_pressed_e6", 32'(bus.pressed), 32'd1);
        tick(1);
        check("release_pressed_e7", 32'(bus.pressed), 32'd0);
        tick(3);
        check("press_strobes", 32'(strobes - base), 32'd1);
        check("press_keyout_hold", 32'(bus.keyout), 32'd5);

        // Async reset while HELD, key kept down through deassert
        key(5);
        tick(10);
        check("held_pressed", 32'(bus.pressed), 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("arst_keyout", 32'(bus.keyout), 32'h1F);
        check("arst_strobe", 32'(bus.strobe), 32'd0);
        check("arst_pressed", 32'(bus.pressed), 32'd0);
        tick(2);
        nrst = 1'b1;
        base = strobes;
        tick(6);
        check("rpress_strobe_e6", 32'(bus.strobe), 32'd0);
        tick(1);
        check("rpress_strobe_e7", 32'(bus.strobe), 32'd1);
        check("rpress_keyout", 32'(bus.keyout), 32'd5);
        bus.pb = '0;
        tick(10);
        check("rpress_strobes", 32'(strobes - base), 32'd1);

        // Priority: keys 7 and 2 together, then key 0 added while held
        base = strobes;
        bus.pb = '0;
        bus.pb[7] = 1'b1;
        bus.pb[2] = 1'b1;
        tick(7);
        check("prio_strobe", 32'(bus.strobe), 32'd1);
        check("prio_keyout", 32'(bus.keyout), 32'd2);
        tick(3);
        bus.pb[0] = 1'b1;
        tick(8);
        check("prio_held_keyout", 32'(bus.keyout), 32'd2);
        check("prio_held_pressed", 32'(bus.pressed), 32'd1);
        check("prio_strobes", 32'(strobes - base), 32'd1);
        bus.pb = '0;
        tick(10);
        check("prio_released", 32'(bus.pressed), 32'd0);

        // Release glitch on key 9, then a genuine second press of key 1
        base = strobes;
        key(9);
        tick(10);
        bus.pb = '0; tick(2);
        key(9);      tick(10);
        check("glitch_pressed", 32'(bus.pressed), 32'd1);
        bus.pb = '0; tick(10);
        check("glitch_strobes", 32'(strobes - base), 32'd1);
        check("glitch_keyout", 32'(bus.keyout), 32'd9);
        check("glitch_released", 32'(bus.pressed), 32'd0);
        key(1);
        tick(7);
        check("second_strobe", 32'(bus.strobe), 32'd1);
        check("second_keyout", 32'(bus.keyout), 32'd1);
        bus.pb = '0;
        tick(10);

        // Key change mid-debounce: key 1 for two synced cycles, then key 4
        base = strobes;
        key(1);
        tick(2);
        key(4);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("kchg_no_strobe", 32'(bus.strobe), 32'd0);
        end
        tick(1);
        check("kchg_strobe", 32'(bus.strobe), 32'd1);
        check("kchg_keyout", 32'(bus.keyout), 32'd4);
        bus.pb = '0;
        tick(10);
        check("kchg_strobes", 32'(strobes - base), 32'd1);

        check("strobe_back_to_back", 32'(consec), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
